points_to_box: RTL and testbench

- Streaming bounding-box builder. Consumes a cluster of LiDAR points (x, y, z), one per handshake, with a last flag marking the end of the cluster.
- Tracks the running per-axis minimum and maximum over the cluster.
- On cluster end, emits the packed 48-bit box_min/box_max word pair, plus a point count, through a valid/ready output.
- Sits between the clustering stage and the box consumers; the consumers unpack the words into six 16-bit coordinates.

---
 rtl/box_pkg.sv | 21 ++
 rtl/axis_minmax.sv | 42 ++++
 rtl/points_to_box.sv | 120 ++++++++++++
 tb/tb_points_to_box.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// Shared definitions for the bounding-box path: coordinate width, packed box
// word layout (also used by the box unpacker) and the box builder states.
package box_pkg;

    localparam int COORD_W = 16;
    localparam int BOX_W   = 3 * COORD_W;

    localparam int X_MSB = 47;
    localparam int X_LSB = 32;
    localparam int Y_MSB = 31;
    localparam int Y_LSB = 16;
    localparam int Z_MSB = 15;
    localparam int Z_LSB = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } box_state_t;

endpackage

// File: rtl/axis_minmax.sv
// Signed running min/max register pair for one axis. min_next/max_next show the
// values after the current load/update so the caller can capture them same-edge.
module axis_minmax #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic                update,
    input  logic signed [W-1:0] p,
    output logic signed [W-1:0] min_next,
    output logic signed [W-1:0] max_next
);

    logic signed [W-1:0] min_q;
    logic signed [W-1:0] max_q;

    // Ties keep the stored value, so equal coordinates leave the registers unchanged.
    always_comb begin
        min_next = min_q;
        max_next = max_q;
        if (load) begin
            min_next = p;
            max_next = p;
        end else if (update) begin
            if (p < min_q) min_next = p;
            if (p > max_q) max_next = p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_next;
            max_q <= max_next;
        end
    end

endmodule

// File: rtl/points_to_box.sv
// Streaming bounding-box builder: folds a cluster of signed (x,y,z) points into
// packed min/max words plus a count. Macro P2B_MIN_POINTS_EN drops small clusters.
module points_to_box #(
    parameter int COORD_W    = box_pkg::COORD_W,
    parameter int CNT_W      = 16,
    parameter int MIN_POINTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   pt_x,
    input  logic [COORD_W-1:0]   pt_y,
    input  logic [COORD_W-1:0]   pt_z,
    input  logic                 pt_valid,
    input  logic                 pt_last,
    output logic                 pt_ready,
    output logic [3*COORD_W-1:0] box_min_out,
    output logic [3*COORD_W-1:0] box_max_out,
    output logic [CNT_W-1:0]     box_count,
    output logic                 box_valid,
    input  logic                 box_ready
`ifdef P2B_MIN_POINTS_EN
    ,
    output logic                 box_dropped
`endif
);
    import box_pkg::*;

`ifdef P2B_MIN_POINTS_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_POINTS);

    box_state_t          state, state_next;
    logic [CNT_W-1:0]    count_q, count_next;
    logic                accept, load, update, clr, finish, drop;
    logic signed [COORD_W-1:0] min_x, max_x, min_y, max_y, min_z, max_z;

    assign accept = pt_valid && pt_ready;

    axis_minmax #(.W(COORD_W)) u_axis_x (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .update(update),
        .p(pt_x), .min_next(min_x), .max_next(max_x)
    );
    axis_minmax #(.W(COORD_W)) u_axis_y (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .update(update),
        .p(pt_y), .min_next(min_y), .max_next(max_y)
    );
    axis_minmax #(.W(COORD_W)) u_axis_z (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .update(update),
        .p(pt_z), .min_next(min_z), .max_next(max_z)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // A finishing cluster heads to OUT unless it is too small and dropping is enabled.
    always_comb begin
        state_next = state;
        count_next = count_q;
        load       = 1'b0;
        update     = 1'b0;
        clr        = 1'b0;
        finish     = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                load       = 1'b1;
                count_next = CNT_W'(1);
                finish     = pt_last;
                state_next = ACCUM;
            end
            ACCUM: if (accept) begin
                update     = 1'b1;
                count_next = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                finish     = pt_last;
            end
            OUT: if (box_ready) begin
                clr        = 1'b1;
                count_next = '0;
                state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
        drop = finish && DROP_EN && (count_next < MIN_CNT);
        if (drop) clr = 1'b1;
        if (finish) state_next = drop ? EMPTY : OUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            box_valid   <= 1'b0;
            pt_ready    <= 1'b1;
            box_min_out <= '0;
            box_max_out <= '0;
            box_count   <= '0;
        end else begin
            count_q   <= drop ? '0 : count_next;
            box_valid <= (state_next == OUT);
            pt_ready  <= (state_next != OUT);
            if (state != OUT && state_next == OUT) begin
                box_min_out <= {min_x, min_y, min_z};
                box_max_out <= {max_x, max_y, max_z};
                box_count   <= count_next;
            end
        end
    end

`ifdef P2B_MIN_POINTS_EN
    always_ff @(posedge clk) begin
        if (rst) box_dropped <= 1'b0;
        else     box_dropped <= drop;
    end
`endif

endmodule

// File: tb/tb_points_to_box.sv
// Scoreboard bench for points_to_box: clusters are modelled as plain lists of points,
// expected boxes are queued at issue time and a monitor pops them on each box handshake.
module tb_points_to_box;
    import box_pkg::*;

    localparam int CW    = 16;
    localparam int CNT_W = 16;
    localparam int MIN_P = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     pt_x, pt_y, pt_z;
    logic              pt_valid, pt_last, pt_ready;
    logic [3*CW-1:0]   box_min_out, box_max_out;
    logic [CNT_W-1:0]  box_count;
    logic              box_valid, box_ready;
`ifdef P2B_MIN_POINTS_EN
    logic              box_dropped;
    int                drops_seen = 0;
    int                drops_exp  = 0;
`endif

    points_to_box #(.COORD_W(CW), .CNT_W(CNT_W), .MIN_POINTS(MIN_P)) dut (
        .clk(clk), .rst(rst),
        .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
        .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
        .box_min_out(box_min_out), .box_max_out(box_max_out),
        .box_count(box_count), .box_valid(box_valid), .box_ready(box_ready)
`ifdef P2B_MIN_POINTS_EN
        , .box_dropped(box_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3*CW-1:0] mn;
        logic [3*CW-1:0] mx;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   px[$], py[$], pz[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;
    bit   rand_rdy = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic bit emitted(input int n);
`ifdef P2B_MIN_POINTS_EN
        return n >= MIN_P;
`else
        return n >= 1;
`endif
    endfunction

    function automatic int rcoord();
        case ($urandom_range(0, 4))
            0: return -32768;
            1: return 32767;
            2, 3: return int'($urandom_range(0, 20)) - 10;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    task automatic fillRandom(input int n);
        px.delete(); py.delete(); pz.delete();
        for (int i = 0; i < n; i++) begin
            px.push_back(rcoord());
            py.push_back(rcoord());
            pz.push_back(rcoord());
        end
    endtask

    // Issues the points in px/py/pz; a complete cluster also gets its box queued.
    task automatic applyStimulus(input bit complete, input bit keep_valid, output int first_stall);
        int n = px.size();
        int stall;
        first_stall = 0;
        if (complete) begin
            int mnx = px[0], mny = py[0], mnz = pz[0];
            int mxx = px[0], mxy = py[0], mxz = pz[0];
            exp_t e;
            foreach (px[i]) begin
                if (px[i] < mnx) mnx = px[i];
                if (py[i] < mny) mny = py[i];
                if (pz[i] < mnz) mnz = pz[i];
                if (px[i] > mxx) mxx = px[i];
                if (py[i] > mxy) mxy = py[i];
                if (pz[i] > mxz) mxz = pz[i];
            end
            e.mn  = {16'(mnx), 16'(mny), 16'(mnz)};
            e.mx  = {16'(mxx), 16'(mxy), 16'(mxz)};
            e.cnt = 16'(n);
            if (emitted(n)) exp_q.push_back(e);
`ifdef P2B_MIN_POINTS_EN
            else drops_exp++;
`endif
        end
        for (int i = 0; i < n; i++) begin
            pt_x     = 16'(px[i]);
            pt_y     = 16'(py[i]);
            pt_z     = 16'(pz[i]);
            pt_valid = 1'b1;
            pt_last  = complete && (i == n - 1);
            @(negedge clk);
            stall = 0;
            while (!pt_ready && stall < 100) begin
                stall++;
                @(negedge clk);
            end
            if (stall >= 100) checkOutput("accept_timeout", 64'(stall), 64'd0);
            if (i == 0) first_stall = stall;
            @(posedge clk);
            #1;
        end
        if (!keep_valid) begin
            pt_valid = 1'b0;
            pt_last  = 1'b0;
        end
    endtask

    task automatic checkResetValues(input string tag);
        @(negedge clk);
        checkOutput({tag, "_box_valid"}, 64'(box_valid), 64'd0);
        checkOutput({tag, "_pt_ready"}, 64'(pt_ready), 64'd1);
        checkOutput({tag, "_box_min"}, 64'(box_min_out), 64'd0);
        checkOutput({tag, "_box_max"}, 64'(box_max_out), 64'd0);
        checkOutput({tag, "_box_count"}, 64'(box_count), 64'd0);
    endtask

    // Monitor: every cycle pt_ready must be the inverse of box_valid; stalled boxes
    // must hold still; each handshake pops and compares one expected box.
    logic [3*CW-1:0]  hold_mn, hold_mx;
    logic [CNT_W-1:0] hold_cnt;
    bit               holding = 1'b0;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            holding = 1'b0;
        end else begin
            checkOutput("pt_ready_vs_box_valid", 64'(pt_ready), 64'(!box_valid));
            if (box_valid) begin
                if (holding) begin
                    checkOutput("stable_min", 64'(box_min_out), 64'(hold_mn));
                    checkOutput("stable_max", 64'(box_max_out), 64'(hold_mx));
                    checkOutput("stable_count", 64'(box_count), 64'(hold_cnt));
                end
                if (box_ready) begin
                    checkOutput("box_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        checkOutput("box_min", 64'(box_min_out), 64'(mon_e.mn));
                        checkOutput("box_max", 64'(box_max_out), 64'(mon_e.mx));
                        checkOutput("box_count", 64'(box_count), 64'(mon_e.cnt));
                    end
                    holding = 1'b0;
                end else begin
                    hold_mn  = box_min_out;
                    hold_mx  = box_max_out;
                    hold_cnt = box_count;
                    holding  = 1'b1;
                end
            end
        end
    end

`ifdef P2B_MIN_POINTS_EN
    always @(negedge clk) begin
        if (mon_en && !rst && box_dropped) drops_seen++;
    end
`endif

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) box_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int st;
        int prev_n;
        int n;
        int w;
        rst = 1'b1; pt_valid = 1'b0; pt_last = 1'b0;
        pt_x = '0; pt_y = '0; pt_z = '0; box_ready = 1'b1;
        repeat (3) @(posedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        $display("[TB] directed three-point cluster");
        px = '{10, -5, 7}; py = '{20, 40, -3}; pz = '{30, 0, 100};
        applyStimulus(1'b1, 1'b0, st);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] single extreme point");
        px = '{-32768}; py = '{32767}; pz = '{0};
        applyStimulus(1'b1, 1'b0, st);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] consumer stall");
        box_ready = 1'b0;
        px = '{5, -7, 3, 9}; py = '{-2, -2, -2, -2}; pz = '{1000, -1000, 0, 12};
        applyStimulus(1'b1, 1'b0, st);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_box_valid", 64'(box_valid), 64'd1);
            checkOutput("stall_pt_ready", 64'(pt_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        box_ready = 1'b1;
        px = '{100, 101, 100, 102}; py = '{200, 199, 200, 200}; pz = '{-1, -1, -1, -1};
        applyStimulus(1'b1, 1'b0, st);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset inside a cluster");
        px = '{50, 60}; py = '{-50, -60}; pz = '{7, 8};
        applyStimulus(1'b0, 1'b0, st);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        px = '{1}; py = '{1}; pz = '{1};
        applyStimulus(1'b1, 1'b0, st);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] back-to-back clusters");
        prev_n = 0;
        for (int k = 0; k < 6; k++) begin
            n = (k == 0) ? MIN_P : int'($urandom_range(1, 6));
            fillRandom(n);
            applyStimulus(1'b1, k < 5, st);
            if (k > 0) checkOutput("b2b_stall_cycles", 64'(st), emitted(prev_n) ? 64'd1 : 64'd0);
            prev_n = n;
        end
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] random clusters with random consumer backpressure");
        rand_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            fillRandom(int'($urandom_range(1, 8)));
            applyStimulus(1'b1, 1'b0, st);
            repeat ($urandom_range(0, 3)) begin
                pt_last = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            pt_last = 1'b0;
        end
        rand_rdy = 1'b0;
        box_ready = 1'b1;

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef P2B_MIN_POINTS_EN
        checkOutput("drop_count", 64'(drops_seen), 64'(drops_exp));
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
